// File: rtl/rs_16_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_16_8_pkg
// Description : Shared RS(16,8) constants and symbol types.
// Revision    : 1.0
// ============================================================================
package rs_16_8_pkg;

  localparam int SYM_BW = 8;
  localparam int N_NUM  = 16;
  localparam int K_NUM  = 8;
  localparam int R_NUM  = N_NUM - K_NUM;
  localparam int IDX_W  = (K_NUM > 1) ? $clog2(K_NUM) : 1;

  typedef logic [SYM_BW-1:0] sym_t;
  typedef logic [IDX_W-1:0]  idx_t;

endpackage
`default_nettype wire

// File: rtl/rs_deframe_bank.sv
`default_nettype none
// ============================================================================
// Module      : rs_deframe_bank
// Description : One ping-pong bank: K_NUM message symbols plus full/err flags.
// Revision    : 1.0
// ============================================================================
module rs_deframe_bank
  import rs_16_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [SYM_BW-1:0] wr_data,
  input  logic              err_set,
  input  logic              commit,
  input  logic              release_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [SYM_BW-1:0] rd_data,
  output logic              full,
  output logic              err
);

  sym_t r_mem [K_NUM];
  logic r_full;
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K_NUM; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  // Commit and release never target the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (commit)          r_full <= 1'b1;
      else if (release_en) r_full <= 1'b0;
      if (release_en)      r_err  <= 1'b0;
      else if (err_set)    r_err  <= 1'b1;
    end
  end

  assign rd_data = r_mem[rd_idx];
  assign full    = r_full;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: rtl/rs_dec_deframer_16_8.sv
`default_nettype none
// ============================================================================
// Module      : rs_dec_deframer_16_8
// Description : Strips RS(16,8) parity, buffers messages in two banks and
//               streams them as valid/ready packets, dropping on overflow.
//               Option: RS_DEFRAMER_SEQ_CHECK_EN enables symbol index checking.
// Revision    : 1.0
// ============================================================================
module rs_dec_deframer_16_8
  import rs_16_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              symb_out_val,
  input  logic [7:0]        symb_out_cnt,
  input  logic [SYM_BW-1:0] symb_corrected,
  output logic              m_val,
  input  logic              m_rdy,
  output logic [SYM_BW-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              m_err,
  output logic              ovf_pulse,
  output logic [7:0]        drop_cnt
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_send  = 1'b1;
  localparam logic [7:0] c_cnt_last = 8'(N_NUM - 1);
  localparam logic [7:0] c_cnt_msg  = 8'(K_NUM);
  localparam idx_t       c_idx_last = idx_t'(K_NUM - 1);

  logic       r_wr_bank;
  logic       r_drop;
  logic       r_ovf;
  logic [7:0] r_drop_cnt;
  logic [0:0] r_state;
  logic       r_rd_bank;
  idx_t       r_rd_idx;

  logic [1:0] w_full;
  logic [1:0] w_err;
  sym_t       w_rd_data [2];
  logic [1:0] w_bank_wr;
  logic [1:0] w_bank_err;
  logic [1:0] w_bank_commit;
  logic [1:0] w_bank_rel;

  logic w_sof;
  logic w_eof;
  logic w_drop;
  logic w_wr_en;
  logic w_commit;
  logic w_seq_err;
  logic w_send;
  logic w_hs;
  logic w_last;
  logic w_release;

  // ---------------------------------------------------------------- write side
  assign w_sof    = symb_out_val && (symb_out_cnt == 8'd0);
  assign w_eof    = symb_out_val && (symb_out_cnt == c_cnt_last);
  // The drop decision is taken at cnt==0 and must already gate that symbol.
  assign w_drop   = (symb_out_cnt == 8'd0) ? w_full[r_wr_bank] : r_drop;
  assign w_wr_en  = symb_out_val && (symb_out_cnt < c_cnt_msg) && !w_drop;
  assign w_commit = w_eof && !w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_drop     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ovf <= w_sof && w_full[r_wr_bank];
      if (w_sof) begin
        r_drop <= w_full[r_wr_bank];
        if (w_full[r_wr_bank] && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_eof)    r_drop    <= 1'b0;
      if (w_commit) r_wr_bank <= ~r_wr_bank;
    end
  end

`ifdef RS_DEFRAMER_SEQ_CHECK_EN
  logic [7:0] r_exp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_cnt <= '0;
    end else if (symb_out_val) begin
      r_exp_cnt <= (symb_out_cnt == c_cnt_last) ? 8'd0 : symb_out_cnt + 8'd1;
    end
  end

  assign w_seq_err = symb_out_val && !w_drop && (symb_out_cnt != r_exp_cnt);
`else
  assign w_seq_err = 1'b0;
`endif

  // --------------------------------------------------------------------- banks
  assign w_bank_wr     = {w_wr_en   &  r_wr_bank, w_wr_en   & ~r_wr_bank};
  assign w_bank_err    = {w_seq_err &  r_wr_bank, w_seq_err & ~r_wr_bank};
  assign w_bank_commit = {w_commit  &  r_wr_bank, w_commit  & ~r_wr_bank};
  assign w_bank_rel    = {w_release &  r_rd_bank, w_release & ~r_rd_bank};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rs_deframe_bank u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (w_bank_wr[b]),
      .wr_idx     (symb_out_cnt[IDX_W-1:0]),
      .wr_data    (symb_corrected),
      .err_set    (w_bank_err[b]),
      .commit     (w_bank_commit[b]),
      .release_en (w_bank_rel[b]),
      .rd_idx     (r_rd_idx),
      .rd_data    (w_rd_data[b]),
      .full       (w_full[b]),
      .err        (w_err[b])
    );
  end

  // ----------------------------------------------------------------- read side
  assign w_send    = (r_state == c_st_send);
  assign w_hs      = w_send && m_rdy;
  assign w_last    = (r_rd_idx == c_idx_last);
  assign w_release = w_hs && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_full[r_rd_bank]) r_state <= c_st_send;
        end
        c_st_send: begin
          if (w_hs) begin
            if (w_last) begin
              r_rd_idx  <= '0;
              r_rd_bank <= ~r_rd_bank;
              if (!w_full[~r_rd_bank]) r_state <= c_st_idle;
            end else begin
              r_rd_idx <= r_rd_idx + idx_t'(1);
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign m_val     = w_send;
  assign m_data    = w_send ? w_rd_data[r_rd_bank] : '0;
  assign m_sop     = w_send && (r_rd_idx == '0);
  assign m_eop     = w_send && w_last;
  assign m_err     = w_send && w_err[r_rd_bank];
  assign ovf_pulse = r_ovf;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rs_dec_deframer_16_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_dec_deframer_16_8
// Description : Randomized self-checking bench with a packet-level model.
// Revision    : 1.0
// ============================================================================
module tb_rs_dec_deframer_16_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       symb_out_val;
  logic [7:0] symb_out_cnt;
  logic [7:0] symb_corrected;
  logic       m_val;
  logic       m_rdy;
  logic [7:0] m_data;
  logic       m_sop;
  logic       m_eop;
  logic       m_err;
  logic       ovf_pulse;
  logic [7:0] drop_cnt;

  rs_dec_deframer_16_8 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .symb_out_val   (symb_out_val),
    .symb_out_cnt   (symb_out_cnt),
    .symb_corrected (symb_corrected),
    .m_val          (m_val),
    .m_rdy          (m_rdy),
    .m_data         (m_data),
    .m_sop          (m_sop),
    .m_eop          (m_eop),
    .m_err          (m_err),
    .ovf_pulse      (ovf_pulse),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level model: a byte queue of expected output plus buffer occupancy.
  logic [7:0] q_data  [$];
  bit         q_known [$];
  bit         q_err   [$];
  int         pkt_cnt;
  int         pos;
  logic [7:0] mb  [2][8];
  bit         mbv [2][8];
  bit         wb;
  bit         m_drop;
  bit         cur_err;
  int         exp_idx;
  int         drop_model;
  bit         exp_ovf;
  bit         mon_en;
  bit         prev_stall;
  logic [10:0] prev_word;
  bit         rdy_rand;

  task automatic model_reset();
    q_data.delete();
    q_known.delete();
    q_err.delete();
    pkt_cnt    = 0;
    pos        = 0;
    wb         = 0;
    m_drop     = 0;
    cur_err    = 0;
    exp_idx    = 0;
    drop_model = 0;
    exp_ovf    = 0;
    prev_stall = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) mbv[b][i] = 0;
  endtask

  always @(negedge clk) begin : p_mon
    int c;
    int occ;
    if (!rst_n || !mon_en) begin
      prev_stall = 0;
    end else begin
      check_eq("ovf_pulse", ovf_pulse, exp_ovf);
      check_eq("drop_cnt", drop_cnt, drop_model);
      occ = pkt_cnt;
      if (m_val) begin
        if (prev_stall) check_eq("stall_hold", {m_data, m_sop, m_eop, m_err}, prev_word);
        if (q_data.size() == 0) begin
          check_eq("spurious_val", m_val, 1'b0);
        end else begin
          if (q_known[0]) check_eq("data", m_data, q_data[0]);
          check_eq("sop", m_sop, pos == 0);
          check_eq("eop", m_eop, pos == 7);
          check_eq("err", m_err, q_err[0]);
          if (m_rdy) begin
            void'(q_data.pop_front());
            void'(q_known.pop_front());
            void'(q_err.pop_front());
            pos++;
            if (pos == 8) begin
              pos = 0;
              pkt_cnt--;
            end
          end
        end
      end
      prev_stall = m_val && !m_rdy;
      prev_word  = {m_data, m_sop, m_eop, m_err};
      exp_ovf = 0;
      if (symb_out_val) begin
        c = int'(symb_out_cnt);
        if (c == 0) begin
          // The bank about to be filled is still occupied only when both hold packets.
          m_drop = (occ == 2);
          if (m_drop) begin
            exp_ovf = 1;
            if (drop_model < 255) drop_model++;
          end
        end
        if (!m_drop) begin
`ifdef RS_DEFRAMER_SEQ_CHECK_EN
          if (c != exp_idx) cur_err = 1;
`endif
          if (c < 8) begin
            mb[wb][c]  = symb_corrected;
            mbv[wb][c] = 1;
          end
        end
        exp_idx = (c == 15) ? 0 : c + 1;
        if (c == 15) begin
          if (!m_drop) begin
            for (int i = 0; i < 8; i++) begin
              q_data.push_back(mb[wb][i]);
              q_known.push_back(mbv[wb][i]);
              q_err.push_back(cur_err);
            end
            pkt_cnt++;
            wb = ~wb;
          end
          cur_err = 0;
          m_drop  = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) m_rdy = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [7:0] d);
    symb_out_val   = 1'b1;
    symb_out_cnt   = 8'(c);
    symb_corrected = d;
    tick();
    symb_out_val   = 1'b0;
  endtask

  task automatic send_cw(input int gap_pct);
    for (int c = 0; c < 16; c++) begin
      put(c, 8'($urandom));
      if (int'($urandom_range(0, 99)) < gap_pct) repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q_data.size() != 0 || m_val) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, q_data.size(), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int cyc;
    rst_n          = 1'b0;
    symb_out_val   = 1'b0;
    symb_out_cnt   = '0;
    symb_corrected = '0;
    m_rdy          = 1'b0;
    rdy_rand       = 0;
    mon_en         = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_val", m_val, 1'b0);
    check_eq("rst_sop_eop_err", {m_sop, m_eop, m_err}, 3'b000);
    check_eq("rst_m_data", m_data, 8'h00);
    check_eq("rst_ovf_drop", {ovf_pulse, drop_cnt}, 9'h000);
    tick();
    rst_n  = 1'b1;
    mon_en = 1;
    tick();

    // Single codeword with known symbols and the 2-cycle commit latency.
    m_rdy = 1'b1;
    for (int c = 0; c < 16; c++) put(c, 8'(8'h10 + c));
    @(negedge clk);
    check_eq("lat_after_e", m_val, 1'b0);
    @(negedge clk);
    check_eq("lat_after_e1", m_val, 1'b1);
    check_eq("first_byte", m_data, 8'h10);
    wait_drain("t1_drain");

    // Two buffered codewords released together must stream without a bubble.
    m_rdy = 1'b0;
    send_cw(0);
    send_cw(0);
    repeat (3) tick();
    m_rdy = 1'b1;
    hs  = 0;
    cyc = 0;
    while (hs < 16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_val && m_rdy) hs++;
    end
    check_eq("b2b_cycles", cyc, 16);
    @(negedge clk);
    check_eq("full_clear", dut.w_full, 2'b00);
    wait_drain("t2_drain");

    // Third codeword overflows while downstream is stalled.
    m_rdy = 1'b0;
    send_cw(0);
    send_cw(0);
    send_cw(0);
    repeat (2) tick();
    check_eq("drop_cnt_one", drop_cnt, 8'd1);
    m_rdy = 1'b1;
    wait_drain("t3_drain");

    // Random backpressure with input gaps.
    rdy_rand = 1;
    for (int k = 0; k < 4; k++) send_cw(30);
    wait_drain("t4_drain");
    rdy_rand = 0;
    tick();

    // Reset in the middle of a codeword with another packet buffered.
    m_rdy = 1'b0;
    send_cw(0);
    for (int c = 0; c <= 5; c++) put(c, 8'($urandom));
    rst_n  = 1'b0;
    mon_en = 0;
    model_reset();
    @(negedge clk);
    check_eq("mid_rst_val", m_val, 1'b0);
    check_eq("mid_rst_flags", {m_sop, m_eop, m_err, ovf_pulse}, 4'h0);
    check_eq("mid_rst_data", m_data, 8'h00);
    check_eq("mid_rst_drop", drop_cnt, 8'h00);
    check_eq("mid_rst_full", dut.w_full, 2'b00);
    tick();
    rst_n  = 1'b1;
    mon_en = 1;
    m_rdy  = 1'b1;
    tick();
    send_cw(0);
    wait_drain("t5_drain");

    // Skipped index 3, then a clean codeword.
    for (int c = 0; c < 16; c++) if (c != 3) put(c, 8'(8'hA0 + c));
    send_cw(0);
    wait_drain("t6_drain");

    check_eq("end_val", m_val, 1'b0);
    check_eq("end_pkts", pkt_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_dec_deframer_16_8.md
# rs_dec_deframer_16_8

Output deframer placed directly after the RS(16,8) decoder. It consumes the corrected symbol stream (`symb_out_val`, `symb_out_cnt`, `symb_corrected`) and strips the 8 parity symbols. It buffers the 8 message symbols of each codeword in a two-bank ping-pong store, then presents them as a packet on a valid/ready stream. The decoder has no backpressure, so this block absorbs downstream stalls and drops whole codewords on overflow.

## Interface
- `SYM_BW`, 8, symbol width in bits
- `N_NUM`, 16, codeword length in symbols
- `K_NUM`, 8, message length in symbols (must be ≤ `N_NUM`)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `symb_out_val`  in  1  corrected symbol valid
- `symb_out_cnt`  in  8  symbol index within the codeword, 0..N_NUM-1
- `symb_corrected`  in  SYM_BW  corrected symbol
- `m_val`  out  1  output byte valid
- `m_rdy`  in  1  downstream ready
- `m_data`  out  SYM_BW  message symbol
- `m_sop`  out  1  first message symbol of the packet
- `m_eop`  out  1  last message symbol of the packet
- `m_err`  out  1  packet sequence-error flag, valid with `m_val`
- `ovf_pulse`  out  1  one-cycle pulse when a codeword is dropped
- `drop_cnt`  out  8  count of dropped codewords, saturates at 255

## Operation
- Symbol layout: index 0 is the first symbol. Indices 0..K_NUM-1 are message; K_NUM..N_NUM-1 are parity and are discarded.
- Write side:
  - `wr_bank` selects the bank being filled.
  - On `symb_out_val` with cnt==0: if `full[wr_bank]`, set `drop`, pulse `ovf_pulse`, and increment `drop_cnt` (saturating).
  - On `symb_out_val` with cnt<K_NUM and `!drop`: write `bank[wr_bank][cnt]`.
  - On cnt==N_NUM-1: if `!drop`, set `full[wr_bank]` and toggle `wr_bank`. Clear `drop` in either case.
- Gaps in `symb_out_val` inside a codeword are legal; the write side simply waits.
- Read FSM:
  - IDLE: `m_val`=0. Go to SEND when `full[rd_bank]`.
  - SEND: `m_val`=1 and `m_data`=`bank[rd_bank][rd_idx]`. `m_sop`=(rd_idx==0); `m_eop`=(rd_idx==K_NUM-1).
  - Each `m_val&&m_rdy` increments `rd_idx`.
  - On the handshake with `m_eop`: clear `full[rd_bank]`, toggle `rd_bank`, and set `rd_idx`=0. Stay in SEND if the other bank is full (no bubble), otherwise go to IDLE.
- Outputs hold stable while `m_val&&!m_rdy`.
- Commit and release in the same cycle always touch different banks; both take effect.
- Reset values: `m_val`, `m_sop`, `m_eop`, `m_err`, `ovf_pulse` = 0; `m_data` = 0; `drop_cnt` = 0; `wr_bank` = `rd_bank` = 0; `full` = 2'b00; FSM in IDLE.
- Reset mid-operation discards any partial and buffered codewords.

## Timing
- Let E be the edge that samples cnt==N_NUM-1. Then `full` is set at E, and `m_val` is high after edge E+1 (2-cycle commit latency).
- With `m_rdy` held at 1, a packet takes exactly K_NUM cycles. Back-to-back buffered packets stream with no idle cycle.
- `ovf_pulse` is high for exactly the cycle after the edge that samples the dropped codeword's cnt==0.
- `drop_cnt` updates on the same edge.

## Configuration
- `RS_DEFRAMER_SEQ_CHECK_EN` defined:
  - The write side tracks the expected index (reset to 0 at cnt==N_NUM-1).
  - Any accepted symbol whose cnt differs from the expected index sets the bank's `err` bit, and tracking resyncs to the received cnt+1.
  - `m_err` = `err[rd_bank]` for every byte of that packet; the bit is cleared when the bank is released.
- Not defined: no tracking logic; `m_err` is tied to 0. Writes remain indexed by the received cnt.

## Structure
- Shared package `rs_16_8_pkg`: `SYM_BW`, `N_NUM`, `K_NUM`, `R_NUM` localparams and the `sym_t` typedef. The decoder stages also use it.
- One sub-module, `rs_deframe_bank`: one bank of K_NUM×SYM_BW registers plus its `full` and `err` flags, with write-port, commit and release inputs. It is instantiated twice.

## Test plan
- One codeword, symbols 0x10..0x1F on cnt 0..15, `m_rdy`=1 → `m_data` is 0x10..0x17 on 8 consecutive cycles, `m_sop` on 0x10, `m_eop` on 0x17, `m_val` rising 2 cycles after the cnt=15 sample.
- Two back-to-back codewords with `m_rdy`=0 until both are committed, then `m_rdy`=1 → 16 contiguous bytes, no bubble between packets; `full` returns to 2'b00.
- Three codewords with `m_rdy`=0 throughout → the third is dropped: `ovf_pulse` for one cycle at its cnt=0, `drop_cnt`=1; the first two are delivered intact afterwards.
- Random `m_rdy` toggling (50%) with a codeword containing gaps in `symb_out_val` → byte order and values are unchanged; `m_data` is stable during stalls.
- Assert `rst_n` low at cnt=5 of a codeword → all outputs 0; the next full codeword after release is delivered normally.
- With `RS_DEFRAMER_SEQ_CHECK_EN`: cnt sequence 0,1,2,4,5..15 → `m_err`=1 on all 8 bytes of that packet, and a following clean codeword gives `m_err`=0.
